// File: rtl/bar_viz_pkg.sv
// Shared height types, FSM encoding and saturating helpers for the bar visualiser.
// Imported by the height tracker, the peak-hold cells and the colour mapper.
package bar_viz_pkg;

  localparam int unsigned NUM_BARS       = 10;
  localparam int unsigned H_W            = 10;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned HOLD_FRAMES_DEF = 30;

  typedef logic [H_W-1:0] height_t;
  typedef height_t height_arr_t [NUM_BARS];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DECAY = 2'd2
  } tracker_state_t;

  // Subtract without wrapping below zero.
  function automatic height_t sat_sub(height_t a, height_t b);
    return (a > b) ? height_t'(a - b) : '0;
  endfunction

endpackage

// File: rtl/bar_peak_hold.sv
// Per-band peak marker: captures new maxima, holds them for HOLD_FRAMES latches,
// then falls by DECAY_STEP per latch but never below the live work height.
module bar_peak_hold
  import bar_viz_pkg::*;
#(
  parameter int unsigned DECAY_STEP  = 8,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    latch_i,
  input  height_t work_i,
  output height_t peak_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  height_t             peak_q, peak_d;
  height_t             decayed;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  always_comb begin
    peak_d  = peak_q;
    hold_d  = hold_q;
    decayed = sat_sub(peak_q, H_W'(DECAY_STEP));
    if (latch_i) begin
      if (work_i >= peak_q) begin
        peak_d = work_i;
        hold_d = HOLD_W'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        peak_d = (decayed > work_i) ? decayed : work_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/bar_height_tracker.sv
// Turns per-band magnitudes into frame-stable bar heights (instant attack, linear decay, clip).
// Define BAR_PEAK_HOLD_EN to build per-band peak markers; otherwise peak_height_o is 0.
module bar_height_tracker
  import bar_viz_pkg::*;
#(
  parameter int unsigned MAG_W      = 16,
  parameter int unsigned MAG_SHIFT  = 6,
  parameter int unsigned MAX_HEIGHT = 470,
  parameter int unsigned DECAY_STEP = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              band_valid_i,
  output logic              band_ready_o,
  input  logic [IDX_W-1:0]  band_idx_i,
  input  logic [MAG_W-1:0]  band_mag_i,
  input  logic              frame_start_i,
  output height_arr_t       bar_height_o,
  output height_arr_t       peak_height_o,
  output logic              frame_done_o,
  output logic              overrun_o,
  output logic              bad_idx_o
);

  tracker_state_t     state_q, state_d;
  height_arr_t        work_q, work_d;
  height_arr_t        bar_q, bar_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               ready_q;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               bad_q, bad_d;

  logic [MAG_W-1:0]   shifted;
  height_t            scaled;
  logic               accept;
  logic               idx_ok;

  // Clip at full width so oversized magnitudes saturate instead of aliasing.
  always_comb begin
    shifted = band_mag_i >> MAG_SHIFT;
    scaled  = (shifted > MAG_W'(MAX_HEIGHT)) ? H_W'(MAX_HEIGHT) : H_W'(shifted);
    accept  = band_valid_i && ready_q;
    idx_ok  = band_idx_i < IDX_W'(NUM_BARS);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bar_d   = bar_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    bad_d   = bad_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (idx_ok) begin
            if (scaled > work_q[band_idx_i]) begin
              work_d[band_idx_i] = scaled;
            end
          end else begin
            bad_d = 1'b1;
          end
        end
        if (frame_start_i) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bar_d   = work_q;
        cnt_d   = '0;
        state_d = DECAY;
      end
      DECAY: begin
        work_d[cnt_q] = sat_sub(work_q[cnt_q], H_W'(DECAY_STEP));
        if (cnt_q == IDX_W'(NUM_BARS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A frame pulse during an update is dropped; the update itself carries on.
    if (frame_start_i && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '{default: '0};
      bar_q   <= '{default: '0};
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bar_q   <= bar_d;
      ready_q <= (state_d == IDLE);
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      bad_q   <= bad_d;
    end
  end

  assign band_ready_o = ready_q;
  assign bar_height_o = bar_q;
  assign frame_done_o = done_q;
  assign overrun_o    = ovr_q;
  assign bad_idx_o    = bad_q;

`ifdef BAR_PEAK_HOLD_EN
  logic latch_c;
  assign latch_c = (state_q == LATCH);

  for (genvar i = 0; i < NUM_BARS; i++) begin : g_peak
    bar_peak_hold #(
      .DECAY_STEP (DECAY_STEP)
    ) u_peak (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .latch_i (latch_c),
      .work_i  (work_q[i]),
      .peak_o  (peak_height_o[i])
    );
  end
`else
  assign peak_height_o = '{default: '0};
`endif

endmodule
